// File: rtl/tiles_bus_bridge.sv
// ---------------------------------------------------------------------------
// TilesBusBridge : Avalon-MM slave that gives a CPU access to the tilemap,
// tileset and palette block RAMs of the tile renderer. It can also
// block-fill the tilemap with a single tile value.
//
// Parameters
//   AUTO_INC : 1 = TM/TS/PAL address registers step after each data write
//
// Optional feature
//   `define TILES_BUS_BRIDGE_FILL_EN to build FILL_LEN, FILL_CTRL, the FILL
//   state and STATUS.busy. Without it, registers 6..8 read 0 and ignore
//   writes, and the bridge never stalls for a fill.
//
// Ports
//   mem_clk, mem_reset_n           : clock, synchronous active-low reset
//   chipselect/write/read/address/
//   writedata/readdata/waitrequest : Avalon-MM slave (16 word registers)
//   tm_*                           : tilemap RAM  (8192 x 8)
//   ts_*                           : tileset RAM  (16384 x 4)
//   palette_*                      : palette RAM  (16 x 24, {B,G,R})
//
// Register map: 0 TM_ADDR, 1 TM_DATA, 2 TS_ADDR, 3 TS_DATA, 4 PAL_ADDR,
//   5 PAL_DATA, 6 FILL_LEN, 7 FILL_CTRL, 8 STATUS, 9..15 read 0.
// ---------------------------------------------------------------------------
module tiles_bus_bridge #(
    parameter int AUTO_INC = 1
) (
    input  logic        mem_clk,
    input  logic        mem_reset_n,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [3:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic [12:0] tm_address,
    output logic        tm_we,
    output logic [7:0]  tm_din,
    input  logic [7:0]  tm_dout,
    output logic [13:0] ts_address,
    output logic        ts_we,
    output logic [3:0]  ts_din,
    input  logic [3:0]  ts_dout,
    output logic [3:0]  palette_address,
    output logic        palette_we,
    output logic [23:0] palette_din,
    input  logic [23:0] palette_dout
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, FILL} state_t;

    state_t      r_state;
    logic [12:0] r_tmAddr;
    logic [13:0] r_tsAddr;
    logic [3:0]  r_palAddr;
    logic        r_tmWe, r_tsWe, r_palWe;
    logic [7:0]  r_tmDin;
    logic [3:0]  r_tsDin;
    logic [23:0] r_palDin;
    logic [1:0]  r_rdSel;
`ifdef TILES_BUS_BRIDGE_FILL_EN
    logic [12:0] r_fillLen;
    logic [12:0] r_fillCnt;
`endif

    logic w_wrReq, w_rdReq, w_dataAddr, w_busy;
    logic w_unused;

    // A simultaneous read and write is a write; the read is ignored.
    assign w_wrReq    = chipselect && write;
    assign w_rdReq    = chipselect && read && !write;
    assign w_dataAddr = (address == 4'd1) || (address == 4'd3) || (address == 4'd5);
    assign w_busy     = (r_state == FILL);
    assign w_unused   = ^writedata[31:24];

    // During a fill the TM_ADDR register itself is the fill pointer, so the
    // RAM address ports can always come straight from the address registers.
    assign tm_address      = r_tmAddr;
    assign ts_address      = r_tsAddr;
    assign palette_address = r_palAddr;
    assign tm_we           = r_tmWe;
    assign tm_din          = r_tmDin;
    assign ts_we           = r_tsWe;
    assign ts_din          = r_tsDin;
    assign palette_we      = r_palWe;
    assign palette_din     = r_palDin;

    // Stall rules: data reads need one extra cycle for the RAM to return
    // data, and a running fill holds off everything except STATUS polling.
    always_comb begin
        waitrequest = 1'b0;
        case (r_state)
            IDLE:    waitrequest = w_rdReq && w_dataAddr;
            RD_WAIT: waitrequest = w_wrReq;
            FILL:    waitrequest = w_wrReq || (w_rdReq && (address != 4'd8));
            default: waitrequest = 1'b0;
        endcase
    end

    // Read mux. In RD_WAIT the RAM's own registered output is presented;
    // otherwise register reads are answered combinationally in one cycle.
    always_comb begin
        readdata = '0;
        if (r_state == RD_WAIT) begin
            case (r_rdSel)
                2'd0:    readdata = {24'b0, tm_dout};
                2'd1:    readdata = {28'b0, ts_dout};
                default: readdata = {8'b0, palette_dout};
            endcase
        end else if (w_rdReq) begin
            case (address)
                4'd0:    readdata = {19'b0, r_tmAddr};
                4'd2:    readdata = {18'b0, r_tsAddr};
                4'd4:    readdata = {28'b0, r_palAddr};
`ifdef TILES_BUS_BRIDGE_FILL_EN
                4'd6:    readdata = {19'b0, r_fillLen};
                4'd8:    readdata = {31'b0, w_busy};
`endif
                default: readdata = '0;
            endcase
        end
    end

    // Main FSM and register file. Write strobes default low so each data
    // write yields a single-cycle pulse. The post-increment happens on the
    // edge that ends the pulse, so the RAM writes at the old address; an
    // explicit address-register write in that same cycle takes priority.
    always_ff @(posedge mem_clk) begin
        if (!mem_reset_n) begin
            r_state   <= IDLE;
            r_tmAddr  <= '0;
            r_tsAddr  <= '0;
            r_palAddr <= '0;
            r_tmWe    <= 1'b0;
            r_tsWe    <= 1'b0;
            r_palWe   <= 1'b0;
            r_tmDin   <= '0;
            r_tsDin   <= '0;
            r_palDin  <= '0;
            r_rdSel   <= '0;
`ifdef TILES_BUS_BRIDGE_FILL_EN
            r_fillLen <= '0;
            r_fillCnt <= '0;
`endif
        end else begin
            r_tmWe  <= 1'b0;
            r_tsWe  <= 1'b0;
            r_palWe <= 1'b0;
            if (AUTO_INC != 0) begin
                if (r_tmWe && (r_state != FILL)) r_tmAddr <= r_tmAddr + 13'd1;
                if (r_tsWe)  r_tsAddr  <= r_tsAddr + 14'd1;
                if (r_palWe) r_palAddr <= r_palAddr + 4'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_wrReq) begin
                        case (address)
                            4'd0: r_tmAddr  <= writedata[12:0];
                            4'd1: begin r_tmWe  <= 1'b1; r_tmDin  <= writedata[7:0];  end
                            4'd2: r_tsAddr  <= writedata[13:0];
                            4'd3: begin r_tsWe  <= 1'b1; r_tsDin  <= writedata[3:0];  end
                            4'd4: r_palAddr <= writedata[3:0];
                            4'd5: begin r_palWe <= 1'b1; r_palDin <= writedata[23:0]; end
`ifdef TILES_BUS_BRIDGE_FILL_EN
                            4'd6: r_fillLen <= writedata[12:0];
                            4'd7: begin
                                if (r_fillLen != 13'd0) begin
                                    r_tmWe    <= 1'b1;
                                    r_tmDin   <= writedata[7:0];
                                    r_fillCnt <= r_fillLen;
                                    r_state   <= FILL;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end else if (w_rdReq && w_dataAddr) begin
                        r_rdSel <= address[2:1];
                        r_state <= RD_WAIT;
                    end
                end
                RD_WAIT: r_state <= IDLE;
`ifdef TILES_BUS_BRIDGE_FILL_EN
                // One tilemap word per cycle; the strobe stays up until the
                // last word has been presented.
                FILL: begin
                    r_tmAddr  <= r_tmAddr + 13'd1;
                    r_fillCnt <= r_fillCnt - 13'd1;
                    if (r_fillCnt == 13'd1) r_state <= IDLE;
                    else                    r_tmWe  <= 1'b1;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
